// File: rtl/cordic_arbiter_if.sv
// Signal bundle between the two angle sources, the shared cordic core and the
// response consumer. The slave side is the arbiter.
interface cordic_arbiter_if #(
   parameter int ANGLE_WIDTH = 16,
   parameter int WL          = 10
);
   logic                   req0_valid;
   logic [ANGLE_WIDTH-1:0] req0_angle;
   logic                   req0_ready;
   logic                   req1_valid;
   logic [ANGLE_WIDTH-1:0] req1_angle;
   logic                   req1_ready;
   logic                   cor_start;
   logic [ANGLE_WIDTH-1:0] cor_angle;
   logic [2*WL-1:0]        cor_result;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic                   rsp_id;
   logic [WL-1:0]          rsp_sin;
   logic [WL-1:0]          rsp_cos;
   logic                   busy;
   logic [15:0]            done_cnt;

   modport slave (
      input  req0_valid, req0_angle, req1_valid, req1_angle, cor_result, rsp_ready,
      output req0_ready, req1_ready, cor_start, cor_angle, rsp_valid, rsp_id,
             rsp_sin, rsp_cos, busy, done_cnt
   );

   modport master (
      output req0_valid, req0_angle, req1_valid, req1_angle, cor_result, rsp_ready,
      input  req0_ready, req1_ready, cor_start, cor_angle, rsp_valid, rsp_id,
             rsp_sin, rsp_cos, busy, done_cnt
   );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one fixed-latency cordic core between two
// requesters; one operation in flight, result returned tagged with the requester id.
module cordic_arbiter #(
   parameter int WI          = 4,
   parameter int WF          = 6,
   parameter int ANGLE_WIDTH = 16,
   parameter int ITERATIONS  = 10,
   parameter int CORE_LAT    = ITERATIONS + 1
) (
   input logic             clk,
   input logic             rst_n,
   cordic_arbiter_if.slave io
);
   localparam int WL = WI + WF;
   localparam int CW = $clog2(CORE_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                      state;
   logic [1:0]                  req_valid;
   logic [1:0]                  req_ready;
   logic [1:0][ANGLE_WIDTH-1:0] req_angle;
   logic                        grant;
   logic                        accept;
   logic                        last_grant;
   logic                        id_q;
   logic [CW-1:0]               cnt;
   logic                        start_q;
   logic                        rsp_valid_q;
   logic                        rsp_id_q;
   logic                        busy_q;
   logic [ANGLE_WIDTH-1:0]      angle_q;
   logic [WL-1:0]               sin_q;
   logic [WL-1:0]               cos_q;
   logic [15:0]                 done_q;

   assign req_valid = {io.req1_valid, io.req0_valid};
   assign req_angle = {io.req1_angle, io.req0_angle};

   // A lone requester wins outright; a tie goes to whoever did not win last.
   always_comb begin
      grant = req_valid[1];
      if (&req_valid) grant = ~last_grant;
   end

   // Gated by rst_n so both readies read 0 while reset is held.
   assign req_ready[0] = rst_n & (state == IDLE) & ~grant;
   assign req_ready[1] = rst_n & (state == IDLE) & grant;
   assign accept       = |(req_valid & req_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         id_q        <= 1'b0;
         cnt         <= '0;
         start_q     <= 1'b0;
         angle_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         sin_q       <= '0;
         cos_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               angle_q    <= req_angle[grant];
               id_q       <= grant;
               last_grant <= grant;
               start_q    <= 1'b1;
               busy_q     <= 1'b1;
               state      <= ISSUE;
            end
            ISSUE: begin
               start_q <= 1'b0;
               cnt     <= CW'(CORE_LAT - 1);
               state   <= WAIT;
            end
            WAIT: begin
               // cnt reaches 0 in the cycle the core result becomes valid
               if (cnt == '0) begin
                  sin_q       <= io.cor_result[2*WL-1:WL];
                  cos_q       <= io.cor_result[WL-1:0];
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: if (io.rsp_ready) begin
               rsp_valid_q <= 1'b0;
               done_q      <= done_q + 16'd1;
               busy_q      <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io.req0_ready = req_ready[0];
   assign io.req1_ready = req_ready[1];
   assign io.cor_start  = start_q;
   assign io.cor_angle  = angle_q;
   assign io.rsp_valid  = rsp_valid_q;
   assign io.rsp_id     = rsp_id_q;
   assign io.rsp_sin    = sin_q;
   assign io.rsp_cos    = cos_q;
   assign io.busy       = busy_q;
   assign io.done_cnt   = done_q;
endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: randomized requesters, a model cordic core, and a
// scoreboard monitor comparing every response against the expected queue.
module tb_cordic_arbiter;
   localparam int WI  = 4;
   localparam int WF  = 6;
   localparam int WL  = WI + WF;
   localparam int AW  = 16;
   localparam int ITR = 10;
   localparam int LAT = ITR + 1;

   typedef struct packed {
      logic          id;
      logic [2*WL-1:0] res;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   force_req = 0;
   bit   fix_en = 1'b0;
   logic [2*WL-1:0] fix_res = '0;
   exp_t q[$];

   always #5 clk = ~clk;

   cordic_arbiter_if #(.ANGLE_WIDTH(AW), .WL(WL)) io ();

   cordic_arbiter #(
      .WI(WI), .WF(WF), .ANGLE_WIDTH(AW), .ITERATIONS(ITR), .CORE_LAT(LAT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .io   (io.slave)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, want, $time);
      end
   endtask

   // Monitor + model core: owns every comparison and the expected-response queue.
   initial begin : monitor
      exp_t            e;
      bit              eg, hs0, hs1, hold, acc_pend, st_pend, last_w, exp_busy, pend_id;
      int              cyc, acc_cyc, start_cyc, force_seen;
      logic [AW-1:0]   pend_ang;
      logic [2*WL-1:0] cur_res;
      logic [2*WL:0]   prev;
      logic [15:0]     exp_done;
      cyc = 0; acc_cyc = 0; start_cyc = 0; force_seen = 0;
      hold = 0; acc_pend = 0; st_pend = 0; last_w = 1; exp_busy = 0; pend_id = 0;
      pend_ang = '0; cur_res = '0; prev = '0; exp_done = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            chk("rst_ready", 32'({io.req1_ready, io.req0_ready}), 32'd0);
            chk("rst_start", 32'(io.cor_start), 32'd0);
            chk("rst_angle", 32'(io.cor_angle), 32'd0);
            chk("rst_rsp", 32'({io.rsp_valid, io.rsp_id, io.rsp_sin, io.rsp_cos}), 32'd0);
            chk("rst_busy", 32'(io.busy), 32'd0);
            chk("rst_done", 32'(io.done_cnt), 32'd0);
            q.delete();
            hold = 0; acc_pend = 0; st_pend = 0; last_w = 1; exp_busy = 0; exp_done = '0;
            io.cor_result = 20'($urandom);
         end else begin
            if (force_req != force_seen) begin
               exp_done   = 16'hFFFF;
               force_seen = force_req;
            end
            chk("busy", 32'(io.busy), 32'(exp_busy));
            chk("done_cnt", 32'(io.done_cnt), 32'(exp_done));
            // Arbitration: ties alternate, a lone requester always wins.
            if (exp_busy)
               chk("stall_ready", 32'({io.req1_ready, io.req0_ready}), 32'd0);
            else if (io.req0_valid || io.req1_valid) begin
               eg = (io.req0_valid && io.req1_valid) ? !last_w : io.req1_valid;
               chk("grant", 32'({io.req1_ready, io.req0_ready}), eg ? 32'd2 : 32'd1);
            end
            hs0 = io.req0_valid && io.req0_ready;
            hs1 = io.req1_valid && io.req1_ready;
            if (hs0 || hs1) begin
               pend_id  = hs1;
               pend_ang = hs1 ? io.req1_angle : io.req0_angle;
               last_w   = hs1;
               acc_cyc  = cyc;
               acc_pend = 1;
               exp_busy = 1;
            end
            if (io.cor_start) begin
               chk("start_after_accept", 32'(acc_pend && cyc == acc_cyc + 1), 32'd1);
               chk("cor_angle", 32'(io.cor_angle), 32'(pend_ang));
               acc_pend  = 0;
               st_pend   = 1;
               start_cyc = cyc;
               cur_res   = fix_en ? fix_res : 20'($urandom);
               q.push_back('{pend_id, cur_res});
            end else if (st_pend) begin
               chk("cor_angle_hold", 32'(io.cor_angle), 32'(pend_ang));
            end
            // Core result is only meaningful in the cycle CORE_LAT after start.
            io.cor_result = (st_pend && cyc == start_cyc + LAT) ? cur_res : 20'($urandom);
            if (io.rsp_valid) begin
               if (hold)
                  chk("rsp_hold", 32'({io.rsp_id, io.rsp_sin, io.rsp_cos}), 32'(prev));
               else begin
                  chk("rsp_latency", cyc, st_pend ? start_cyc + LAT + 1 : -1);
                  st_pend = 0;
               end
               if (io.rsp_ready) begin
                  if (q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                  else begin
                     e = q.pop_front();
                     chk("rsp_id", 32'(io.rsp_id), 32'(e.id));
                     chk("rsp_sin", 32'($signed(io.rsp_sin)), 32'($signed(e.res[2*WL-1:WL])));
                     chk("rsp_cos", 32'($signed(io.rsp_cos)), 32'($signed(e.res[WL-1:0])));
                  end
                  exp_done++;
                  exp_busy = 0;
               end
               prev = {io.rsp_id, io.rsp_sin, io.rsp_cos};
               hold = !io.rsp_ready;
            end else begin
               if (hold) chk("rsp_dropped", 32'd0, 32'd1);
               hold = 0;
            end
         end
      end
   end

   task automatic wait_hs(input bit ch, input string nm);
      bit hit = 0;
      for (int k = 0; k < 300 && !hit; k++) begin
         @(negedge clk);
         hit = ch ? (io.req1_valid && io.req1_ready) : (io.req0_valid && io.req0_ready);
      end
      if (!hit) begin
         $display("FAIL timeout %s", nm);
         $fatal(1);
      end
      @(posedge clk); #1;
   endtask

   task automatic send(input bit ch, input logic [AW-1:0] ang);
      if (ch) begin io.req1_valid = 1; io.req1_angle = ang; end
      else    begin io.req0_valid = 1; io.req0_angle = ang; end
      wait_hs(ch, "send");
      if (ch) io.req1_valid = 0; else io.req0_valid = 0;
   endtask

   task automatic drain();
      bit hit = 0;
      io.rsp_ready = 1;
      for (int k = 0; k < 300 && !hit; k++) begin
         @(negedge clk);
         hit = !io.busy && !io.rsp_valid;
      end
      if (!hit) begin
         $display("FAIL timeout drain");
         $fatal(1);
      end
      @(posedge clk); #1;
   endtask

   task automatic run_ops(input int n, input int vprob, input int rdy_pct);
      int issued = 0;
      int acc = 0;
      bit h0, h1;
      for (int c = 0; c < n * 60 + 200 && acc < n; c++) begin
         if (!io.req0_valid && issued < n && int'($urandom_range(99)) < vprob) begin
            io.req0_angle = 16'($urandom); io.req0_valid = 1; issued++;
         end
         if (!io.req1_valid && issued < n && int'($urandom_range(99)) < vprob) begin
            io.req1_angle = 16'($urandom); io.req1_valid = 1; issued++;
         end
         io.rsp_ready = int'($urandom_range(99)) < rdy_pct;
         @(negedge clk);
         h0 = io.req0_valid && io.req0_ready;
         h1 = io.req1_valid && io.req1_ready;
         acc += int'(h0) + int'(h1);
         @(posedge clk); #1;
         if (h0) io.req0_valid = 0;
         if (h1) io.req1_valid = 0;
      end
      if (acc < n) begin
         $display("FAIL timeout run_ops");
         $fatal(1);
      end
      drain();
   endtask

   task automatic do_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
   endtask

   initial begin : stim
      bit hit = 0;
      io.req0_valid = 0; io.req0_angle = '0;
      io.req1_valid = 0; io.req1_angle = '0;
      io.rsp_ready  = 1;
      do_reset();

      // Single ch0 op at 40 degrees
      send(0, 16'h1C72);
      drain();

      // Both held valid for four ops from a fresh reset
      do_reset();
      run_ops(4, 100, 100);

      // Consumer stalls five cycles while ch1 waits
      io.rsp_ready = 0;
      send(0, 16'h4000);
      io.req1_valid = 1; io.req1_angle = 16'h2345;
      for (int k = 0; k < 100 && !hit; k++) begin
         @(negedge clk);
         hit = io.rsp_valid;
      end
      if (!hit) begin
         $display("FAIL timeout stall_rsp");
         $fatal(1);
      end
      repeat (5) @(posedge clk);
      #1 io.rsp_ready = 1;
      wait_hs(1, "stall_ch1");
      io.req1_valid = 0;
      drain();

      // Exact slices, positive then negative
      fix_en = 1;
      fix_res = {10'h0A5, 10'h0C3};
      send(1, 16'h1111);
      drain();
      fix_res = {10'h3A5, 10'h2C3};
      send(0, 16'hC000);
      drain();
      fix_en = 0;

      // Reset in WAIT with cnt == 4, i.e. seven cycles after the start pulse
      send(1, 16'h7777);
      hit = 0;
      for (int k = 0; k < 20 && !hit; k++) begin
         @(negedge clk);
         hit = io.cor_start;
      end
      if (!hit) begin
         $display("FAIL timeout mid_reset_start");
         $fatal(1);
      end
      repeat (7) @(posedge clk);
      #1 rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      repeat (20) @(posedge clk);
      #1 io.req0_valid = 1; io.req1_valid = 1;
      io.req0_angle = 16'h0100; io.req1_angle = 16'h0200;
      wait_hs(0, "post_reset_grant");
      io.req0_valid = 0; io.req1_valid = 0;
      drain();

      // Randomized traffic with a sometimes-stalling consumer
      run_ops(30, 50, 70);

      // Counter wrap
      force dut.done_q = 16'hFFFF;
      force_req++;
      @(posedge clk); #1;
      release dut.done_q;
      send(1, 16'h0ABC);
      drain();
      repeat (5) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
